bsg_nonsynth_random_rr_server: RTL and testbench

BSG_NONSYNTH_RANDOM_RR_SERVER -- requirements
Module: bsg_nonsynth_random_rr_server

---
 rtl/bsg_nonsynth_random_rr_server.sv | 112 +++++++++++
 tb/tb_bsg_nonsynth_random_rr_server.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bsg_nonsynth_random_rr_server.sv
// Round-robin server handing out one shared Galois-LFSR word per grant; a grant is visible the cycle after request, consumed on yumi.
// Define BSG_NONSYNTH_RANDOM_RR_SERVER_CHECK_EN to flag stray or multi-hot yumi_i with $error.
module bsg_nonsynth_random_rr_server #(
  parameter int                 els_p   = 4,
  parameter int                 width_p = 16,
  parameter logic [width_p-1:0] seed_p  = 16'hACE1,
  parameter logic [width_p-1:0] taps_p  = 16'hB400
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [els_p-1:0]   req_i,
  input  logic [els_p-1:0]   yumi_i,
  output logic [els_p-1:0]   v_o,
  output logic [width_p-1:0] data_o,
  output logic [31:0]        count_o
);

  localparam int iw_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cw_lp = iw_lp + 1;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e             state_r, state_n;
  logic [iw_lp-1:0]   g_r, g_n;
  logic [iw_lp-1:0]   ptr_r, ptr_n;
  logic [width_p-1:0] lfsr_r, lfsr_n;
  logic [31:0]        count_r, count_n;

  logic               win_found;
  logic [iw_lp-1:0]   win_idx;
  logic [cw_lp-1:0]   cand;

  // Search req_i starting at ptr_r, wrapping at els_p; first hit wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < els_p; i++) begin
      cand = {1'b0, ptr_r} + cw_lp'(i);
      if (cand >= cw_lp'(els_p))
        cand = cand - cw_lp'(els_p);
      if (!win_found && req_i[cand[iw_lp-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[iw_lp-1:0];
      end
    end
  end

  always_comb begin
    state_n = state_r;
    g_n     = g_r;
    ptr_n   = ptr_r;
    lfsr_n  = lfsr_r;
    count_n = count_r;
    case (state_r)
      IDLE: begin
        if (win_found) begin
          state_n = GRANT;
          g_n     = win_idx;
        end
      end
      GRANT: begin
        // A consume in the same cycle as request withdrawal still counts.
        if (yumi_i[g_r]) begin
          state_n = IDLE;
          lfsr_n  = (lfsr_r >> 1) ^ (lfsr_r[0] ? taps_p : '0);
          ptr_n   = (g_r == iw_lp'(els_p - 1)) ? '0 : g_r + iw_lp'(1);
          count_n = count_r + 32'd1;
        end else if (!req_i[g_r]) begin
          state_n = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      g_r     <= '0;
      ptr_r   <= '0;
      lfsr_r  <= seed_p;
      count_r <= '0;
    end else begin
      state_r <= state_n;
      g_r     <= g_n;
      ptr_r   <= ptr_n;
      lfsr_r  <= lfsr_n;
      count_r <= count_n;
    end
  end

  always_comb begin
    v_o = '0;
    if (state_r == GRANT)
      v_o[g_r] = 1'b1;
  end

  assign data_o  = lfsr_r;
  assign count_o = count_r;

`ifdef BSG_NONSYNTH_RANDOM_RR_SERVER_CHECK_EN
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if ($countones(yumi_i) > 1)
        $error("bsg_nonsynth_random_rr_server: multiple yumi_i bits set: %b", yumi_i);
      else if ((yumi_i != '0) && (yumi_i != v_o))
        $error("bsg_nonsynth_random_rr_server: yumi_i %b without matching grant %b", yumi_i, v_o);
    end
  end
`endif

endmodule

// File: tb/tb_bsg_nonsynth_random_rr_server.sv
// Directed bench for bsg_nonsynth_random_rr_server: reset, single grant, round robin, drop/hold, mid-grant reset, stray yumi.
module tb_bsg_nonsynth_random_rr_server;

  logic        clk_i;
  logic        reset_i;
  logic [3:0]  req_i;
  logic [3:0]  yumi_i;
  logic [3:0]  v_o;
  logic [15:0] data_o;
  logic [31:0] count_o;

  int total;
  int bad;

  bsg_nonsynth_random_rr_server #(
    .els_p(4), .width_p(16), .seed_p(16'hACE1), .taps_p(16'hB400)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .req_i  (req_i),
    .yumi_i (yumi_i),
    .v_o    (v_o),
    .data_o (data_o),
    .count_o(count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Hand-derived LFSR sequence from seed 16'hACE1 with taps 16'hB400.
  localparam logic [15:0] L0 = 16'hACE1;
  localparam logic [15:0] L1 = 16'hE270;
  localparam logic [15:0] L5 = 16'h0E27;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    req_i   = '0;
    yumi_i  = '0;
    reset_i = 1'b1;
    #1;
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    reset_i = 1'b1;
    #1;
    total++;
    if (v_o !== 4'b0000) begin bad++; $display("FAIL reset_v_o got=%b want=%b", v_o, 4'b0000); end
    total++;
    if (data_o !== L0) begin bad++; $display("FAIL reset_data got=%h want=%h", data_o, L0); end
    total++;
    if (count_o !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count_o); end
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  task automatic test_single_grant();
    req_i = 4'b0100;
    step();
    total++;
    if (v_o !== 4'b0100) begin bad++; $display("FAIL single_grant got=%b want=%b", v_o, 4'b0100); end
    yumi_i = 4'b0100;
    step();
    yumi_i = '0;
    req_i  = '0;
    total++;
    if (v_o !== 4'b0000) begin bad++; $display("FAIL single_after_v got=%b want=%b", v_o, 4'b0000); end
    total++;
    if (data_o !== L1) begin bad++; $display("FAIL single_data got=%h want=%h", data_o, L1); end
    total++;
    if (count_o !== 32'd1) begin bad++; $display("FAIL single_count got=%0d want=1", count_o); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    req_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp = 4'b0001 << (k % 4);
      step();
      total++;
      if (v_o !== exp) begin bad++; $display("FAIL rr_grant%0d got=%b want=%b", k, v_o, exp); end
      yumi_i = exp;
      step();
      yumi_i = '0;
      total++;
      if (v_o !== 4'b0000) begin bad++; $display("FAIL rr_idle%0d got=%b want=0000", k, v_o); end
    end
    req_i = '0;
    total++;
    if (count_o !== 32'd5) begin bad++; $display("FAIL rr_count got=%0d want=5", count_o); end
    total++;
    if (data_o !== L5) begin bad++; $display("FAIL rr_data got=%h want=%h", data_o, L5); end
  endtask

  task automatic test_drop_and_hold();
    do_reset();
    req_i = 4'b0010;
    step();
    total++;
    if (v_o !== 4'b0010) begin bad++; $display("FAIL drop_grant got=%b want=0010", v_o); end
    step();
    step();
    total++;
    if (v_o !== 4'b0010 || data_o !== L0) begin
      bad++; $display("FAIL hold got=%b/%h want=0010/%h", v_o, data_o, L0);
    end
    req_i = '0;
    step();
    total++;
    if (v_o !== 4'b0000) begin bad++; $display("FAIL drop_v got=%b want=0000", v_o); end
    total++;
    if (data_o !== L0 || count_o !== 32'd0) begin
      bad++; $display("FAIL drop_state got=%h/%0d want=%h/0", data_o, count_o, L0);
    end
    req_i = 4'b1010;
    step();
    total++;
    if (v_o !== 4'b0010) begin bad++; $display("FAIL drop_ptr got=%b want=0010", v_o); end
    // Withdraw and consume together: the consume wins.
    req_i  = '0;
    yumi_i = 4'b0010;
    step();
    yumi_i = '0;
    total++;
    if (count_o !== 32'd1 || data_o !== L1) begin
      bad++; $display("FAIL yumi_prio got=%0d/%h want=1/%h", count_o, data_o, L1);
    end
    req_i = 4'b1111;
    step();
    total++;
    if (v_o !== 4'b0100) begin bad++; $display("FAIL yumi_prio_ptr got=%b want=0100", v_o); end
    req_i = '0;
    step();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req_i = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      step();
      yumi_i = 4'b0001 << k;
      step();
      yumi_i = '0;
    end
    step();
    total++;
    if (v_o !== 4'b1000 || count_o !== 32'd3) begin
      bad++; $display("FAIL mid_pre got=%b/%0d want=1000/3", v_o, count_o);
    end
    reset_i = 1'b1;
    #1;
    total++;
    if (v_o !== 4'b0000) begin bad++; $display("FAIL mid_reset_v got=%b want=0000", v_o); end
    total++;
    if (data_o !== L0 || count_o !== 32'd0) begin
      bad++; $display("FAIL mid_reset_state got=%h/%0d want=%h/0", data_o, count_o, L0);
    end
    reset_i = 1'b0;
    step();
    total++;
    if (v_o !== 4'b0001) begin bad++; $display("FAIL mid_first_grant got=%b want=0001", v_o); end
    req_i = '0;
    step();
  endtask

  task automatic test_stray_yumi();
    do_reset();
    req_i = 4'b0001;
    step();
    yumi_i = 4'b1000;
    step();
    yumi_i = '0;
    total++;
    if (v_o !== 4'b0001 || data_o !== L0 || count_o !== 32'd0) begin
      bad++; $display("FAIL stray_grant got=%b/%h/%0d want=0001/%h/0", v_o, data_o, count_o, L0);
    end
    req_i = '0;
    step();
    yumi_i = 4'b0001;
    step();
    yumi_i = '0;
    total++;
    if (v_o !== 4'b0000 || data_o !== L0 || count_o !== 32'd0) begin
      bad++; $display("FAIL stray_idle got=%b/%h/%0d want=0000/%h/0", v_o, data_o, count_o, L0);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_i = 1'b0;
    req_i   = '0;
    yumi_i  = '0;
    test_reset();
    test_single_grant();
    test_round_robin();
    test_drop_and_hold();
    test_reset_mid_grant();
    test_stray_yumi();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
